// File: rtl/rast_iter_pkg.sv
// Shared types for the sample iterator: FSM states, subsample encodings, bbox struct and step helper.
package rast_iter_pkg;

    localparam int unsigned SigFig = 24;
    localparam int unsigned Radix  = 10;

    typedef enum logic [0:0] {
        StWait,
        StTest
    } iter_state_e;

    localparam logic [3:0] SubStep1 = 4'b1000;
    localparam logic [3:0] SubStep2 = 4'b0100;
    localparam logic [3:0] SubStep4 = 4'b0010;
    localparam logic [3:0] SubStep8 = 4'b0001;

    typedef struct packed {
        logic [SigFig-1:0] ll_x;
        logic [SigFig-1:0] ll_y;
        logic [SigFig-1:0] ur_x;
        logic [SigFig-1:0] ur_y;
    } bbox_t;

    // Anything that is not exactly one-hot falls back to a full-pixel step.
    function automatic logic [SigFig-1:0] step_from_subsample(input logic [3:0] sub,
                                                              input int unsigned radix);
        int unsigned k;
        case (sub)
            SubStep2: k = 1;
            SubStep4: k = 2;
            SubStep8: k = 3;
            default:  k = 0;
        endcase
        return {{(SigFig-1){1'b0}}, 1'b1} << (radix - k);
    endfunction

endpackage

// File: rtl/sample_step_gen.sv
// Combinational raster step: next sample position and last-sample flag for the current box.
module sample_step_gen #(
    parameter int unsigned SIGFIG = 24
) (
    input  logic [SIGFIG-1:0] x_i,
    input  logic [SIGFIG-1:0] y_i,
    input  logic [SIGFIG-1:0] ll_x_i,
    input  logic [SIGFIG-1:0] ur_x_i,
    input  logic [SIGFIG-1:0] ur_y_i,
    input  logic [SIGFIG-1:0] step_i,
    output logic [SIGFIG-1:0] next_x_o,
    output logic [SIGFIG-1:0] next_y_o,
    output logic              last_o
);

    // One extra bit so x+step near the positive edge cannot wrap negative.
    logic signed [SIGFIG:0] x_inc;
    logic signed [SIGFIG:0] y_inc;
    logic signed [SIGFIG:0] ur_x_ext;
    logic signed [SIGFIG:0] ur_y_ext;
    logic                   x_fits;
    logic                   y_fits;

    always_comb begin
        x_inc    = $signed({x_i[SIGFIG-1], x_i}) + $signed({1'b0, step_i});
        y_inc    = $signed({y_i[SIGFIG-1], y_i}) + $signed({1'b0, step_i});
        ur_x_ext = $signed({ur_x_i[SIGFIG-1], ur_x_i});
        ur_y_ext = $signed({ur_y_i[SIGFIG-1], ur_y_i});
        x_fits   = (x_inc <= ur_x_ext);
        y_fits   = (y_inc <= ur_y_ext);
        next_x_o = x_fits ? x_inc[SIGFIG-1:0] : ll_x_i;
        next_y_o = x_fits ? y_i : y_inc[SIGFIG-1:0];
        last_o   = !x_fits && !y_fits;
    end

endmodule

// File: rtl/sample_iter_ctrl.sv
// Walks sample positions across one bounding box in raster order with downstream backpressure.
// Optional SAMP_ITER_PERF_EN adds saturating handshake and stall counters.
module sample_iter_ctrl
    import rast_iter_pkg::*;
#(
    parameter int unsigned SIGFIG = SigFig,
    parameter int unsigned RADIX  = Radix,
    parameter int unsigned TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              box_valid_i,
    input  logic [SIGFIG-1:0] box_ll_x_i,
    input  logic [SIGFIG-1:0] box_ll_y_i,
    input  logic [SIGFIG-1:0] box_ur_x_i,
    input  logic [SIGFIG-1:0] box_ur_y_i,
    input  logic [TAG_W-1:0]  box_tag_i,
    input  logic [3:0]        subsample_i,
    output logic              halt_o,
    input  logic              samp_ready_i,
    output logic              samp_valid_o,
    output logic [SIGFIG-1:0] samp_x_o,
    output logic [SIGFIG-1:0] samp_y_o,
    output logic [TAG_W-1:0]  samp_tag_o,
    output logic              samp_last_o
`ifdef SAMP_ITER_PERF_EN
    ,
    output logic [31:0]       perf_samples_o,
    output logic [31:0]       perf_stall_o
`endif
);

    iter_state_e       state_q, state_d;
    bbox_t             box_q, box_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [SIGFIG-1:0] step_q, step_d;
    logic [SIGFIG-1:0] x_q, x_d;
    logic [SIGFIG-1:0] y_q, y_d;

    logic [SIGFIG-1:0] next_x;
    logic [SIGFIG-1:0] next_y;
    logic              step_last;
    logic              degenerate;

    assign degenerate = ($signed(box_ur_x_i) < $signed(box_ll_x_i)) ||
                        ($signed(box_ur_y_i) < $signed(box_ll_y_i));

    sample_step_gen #(
        .SIGFIG(SIGFIG)
    ) u_step_gen (
        .x_i     (x_q),
        .y_i     (y_q),
        .ll_x_i  (box_q.ll_x),
        .ur_x_i  (box_q.ur_x),
        .ur_y_i  (box_q.ur_y),
        .step_i  (step_q),
        .next_x_o(next_x),
        .next_y_o(next_y),
        .last_o  (step_last)
    );

    always_comb begin
        state_d = state_q;
        box_d   = box_q;
        tag_d   = tag_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            StWait: begin
                if (box_valid_i && !degenerate) begin
                    box_d.ll_x = box_ll_x_i;
                    box_d.ll_y = box_ll_y_i;
                    box_d.ur_x = box_ur_x_i;
                    box_d.ur_y = box_ur_y_i;
                    tag_d      = box_tag_i;
                    step_d     = step_from_subsample(subsample_i, RADIX);
                    x_d        = box_ll_x_i;
                    y_d        = box_ll_y_i;
                    state_d    = StTest;
                end
            end
            StTest: begin
                if (samp_ready_i) begin
                    if (step_last) begin
                        state_d = StWait;
                    end else begin
                        x_d = next_x;
                        y_d = next_y;
                    end
                end
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWait;
            box_q   <= '0;
            tag_q   <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            box_q   <= box_d;
            tag_q   <= tag_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign halt_o       = (state_q == StTest);
    assign samp_valid_o = (state_q == StTest);
    assign samp_x_o     = x_q;
    assign samp_y_o     = y_q;
    assign samp_tag_o   = tag_q;
    assign samp_last_o  = (state_q == StTest) && step_last;

`ifdef SAMP_ITER_PERF_EN
    logic [31:0] perf_samples_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_samples_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (samp_valid_o && samp_ready_i && (perf_samples_q != '1)) begin
                perf_samples_q <= perf_samples_q + 32'd1;
            end
            if (samp_valid_o && !samp_ready_i && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_samples_o = perf_samples_q;
    assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Self-checking bench for sample_iter_ctrl: directed cases plus random boxes against a queue model.
module tb_sample_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        box_valid;
    logic [23:0] bx_ll_x, bx_ll_y, bx_ur_x, bx_ur_y;
    logic [7:0]  bx_tag;
    logic [3:0]  sub;
    logic        ready;
    logic        halt, s_valid, s_last;
    logic [23:0] s_x, s_y;
    logic [7:0]  s_tag;
`ifdef SAMP_ITER_PERF_EN
    logic [31:0] perf_samples, perf_stall;
`endif

    always #5 clk = ~clk;

    sample_iter_ctrl #(
        .SIGFIG(24),
        .RADIX (10),
        .TAG_W (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .box_valid_i   (box_valid),
        .box_ll_x_i    (bx_ll_x),
        .box_ll_y_i    (bx_ll_y),
        .box_ur_x_i    (bx_ur_x),
        .box_ur_y_i    (bx_ur_y),
        .box_tag_i     (bx_tag),
        .subsample_i   (sub),
        .halt_o        (halt),
        .samp_ready_i  (ready),
        .samp_valid_o  (s_valid),
        .samp_x_o      (s_x),
        .samp_y_o      (s_y),
        .samp_tag_o    (s_tag),
        .samp_last_o   (s_last)
`ifdef SAMP_ITER_PERF_EN
        ,
        .perf_samples_o(perf_samples),
        .perf_stall_o  (perf_stall)
`endif
    );

    typedef struct {
        longint x;
        longint y;
        longint tag;
    } samp_t;

    samp_t  exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     after_rst = 1'b0;
    longint m_samples = 0;
    longint m_stall   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic longint model_step(input logic [3:0] s);
        case (s)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    function automatic longint sx(input logic [23:0] v);
        return longint'($signed(v));
    endfunction

    // Enumerate every sample of a box in raster order.
    task automatic model_fill();
        longint st = model_step(sub);
        for (longint yy = sx(bx_ll_y); yy <= sx(bx_ur_y); yy += st) begin
            for (longint xx = sx(bx_ll_x); xx <= sx(bx_ur_x); xx += st) begin
                samp_t s;
                s.x = xx;
                s.y = yy;
                s.tag = longint'(bx_tag);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("valid", longint'(s_valid), longint'(exp_q.size() != 0));
        check("halt", longint'(halt), longint'(exp_q.size() != 0));
        check("last", longint'(s_last), longint'(exp_q.size() == 1));
        if (exp_q.size() != 0) begin
            check("x", sx(s_x), exp_q[0].x);
            check("y", sx(s_y), exp_q[0].y);
            check("tag", longint'(s_tag), exp_q[0].tag);
        end else if (after_rst) begin
            check("rst_x", longint'(s_x), 0);
            check("rst_y", longint'(s_y), 0);
            check("rst_tag", longint'(s_tag), 0);
        end
`ifdef SAMP_ITER_PERF_EN
        check("perf_samples", longint'(perf_samples), m_samples);
        check("perf_stall", longint'(perf_stall), m_stall);
`endif
        if (rst) begin
            exp_q.delete();
            after_rst = 1'b1;
            m_samples = 0;
            m_stall   = 0;
        end else begin
            after_rst = 1'b0;
            if (exp_q.size() != 0) begin
                if (ready) begin
                    void'(exp_q.pop_front());
                    m_samples++;
                end else begin
                    m_stall++;
                end
            end else if (box_valid && sx(bx_ur_x) >= sx(bx_ll_x) && sx(bx_ur_y) >= sx(bx_ll_y)) begin
                model_fill();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        box_valid = 1'b0;
        ready = 1'b1;
        while (exp_q.size() != 0 && n < 1000) begin
            cycle();
            n++;
        end
        check("drain", longint'(exp_q.size()), 0);
        cycle();
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury,
                           input logic [7:0] t, input logic [3:0] s);
        bx_ll_x = 24'(llx);
        bx_ll_y = 24'(lly);
        bx_ur_x = 24'(urx);
        bx_ur_y = 24'(ury);
        bx_tag  = t;
        sub     = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        box_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        box_valid = 1'b0;
        ready = 1'b1;
        set_box(0, 0, 0, 0, 8'h00, 4'b1000);
        @(posedge clk);
        #1;
        do_reset();
        cycle();

        // 1x1 pixel pitch over a 2x2 grid
        set_box(0, 0, 'h400, 'h400, 8'hA1, 4'b1000);
        box_valid = 1'b1;
        cycle();
        drain();

        // half-pixel step: 3x3 grid
        set_box(0, 0, 'h400, 'h400, 8'hA2, 4'b0100);
        box_valid = 1'b1;
        cycle();
        sub = 4'b0001;
        drain();

        // backpressure in the second and third sample cycles
        set_box(0, 0, 'h400, 'h400, 8'hA3, 4'b1000);
        box_valid = 1'b1;
        cycle();
        box_valid = 1'b0;
        cycle();
        ready = 1'b0;
        cycle();
        cycle();
        drain();

        // degenerate box followed immediately by a real one
        set_box('h800, 0, 'h400, 'h400, 8'hA4, 4'b1000);
        box_valid = 1'b1;
        cycle();
        set_box('h400, 'h400, 'h800, 'h400, 8'hA5, 4'b1000);
        cycle();
        drain();

        // reset during the second sample, then a fresh box at a new corner
        set_box(0, 0, 'h400, 'h400, 8'hA6, 4'b1000);
        box_valid = 1'b1;
        cycle();
        box_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        set_box(-'h800, -'h400, -'h400, 0, 8'hA7, 4'b0100);
        box_valid = 1'b1;
        cycle();
        drain();

        // positive edge of the coordinate range
        do_reset();
        set_box('h7FF800, 0, 'h7FFC00, 0, 8'hA8, 4'b1000);
        box_valid = 1'b1;
        cycle();
        drain();
`ifdef SAMP_ITER_PERF_EN
        check("perf_edge", longint'(perf_samples), 2);
`endif

        // random traffic, including illegal subsample codes and stray resets
        for (int i = 0; i < 3000; i++) begin
            int base_x = (int'($urandom_range(0, 40)) - 20) * 'h400;
            int base_y = (int'($urandom_range(0, 40)) - 20) * 'h400;
            int nx = int'($urandom_range(0, 3)) - 1;
            int ny = int'($urandom_range(0, 3)) - 1;
            logic [3:0] s;
            case ($urandom_range(0, 4))
                0: s = 4'b1000;
                1: s = 4'b0100;
                2: s = 4'b0010;
                3: s = 4'b0001;
                default: s = 4'($urandom);
            endcase
            set_box(base_x, base_y, base_x + nx * 'h400, base_y + ny * 'h400,
                    8'($urandom), s);
            box_valid = ($urandom_range(0, 1) == 1);
            ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
